// File: rtl/prog_loader.sv
// Program loader: streams instruction words into instruction memory while holding
// the core in reset, then releases the core once the last word has been written.
module prog_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(1) << ADDR_W;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W:0]   len_r;
  logic              len_ok;
  logic              last;

  assign len_ok = (load_len != '0) && (load_len <= MAX_LEN);
  // Compare against len-1 so a full 2^ADDR_W load ends as the counter wraps to 0.
  assign last   = ({1'b0, cnt} == (len_r - (ADDR_W+1)'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      len_r      <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      checksum   <= '0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (load_start) begin
            if (len_ok) begin
              state    <= LOAD;
              len_r    <= load_len;
              cnt      <= '0;
              checksum <= '0;
              core_rst <= 1'b1;
              in_ready <= 1'b1;
              busy     <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            imem_we    <= 1'b1;
            imem_addr  <= cnt;
            imem_wdata <= in_data;
            cnt        <= cnt + ADDR_W'(1);
            checksum   <= checksum + in_data;
            if (last) begin
              state    <= FLUSH;
              in_ready <= 1'b0;
            end
          end
        end
        FLUSH: begin
          state    <= RUN;
          busy     <= 1'b0;
          core_rst <= 1'b0;
          done     <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          core_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: drives at the falling edge, checks at the falling
// edge, and logs every memory write seen just after each rising edge.
module tb_prog_loader;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_start = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready, imem_we, core_rst, busy, done, err;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata, checksum;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [ADDR_W-1:0] wa[$];
  logic [DATA_W-1:0] wd[$];

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .busy(busy), .done(done), .err(err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic start(input logic [ADDR_W:0] len);
    load_start = 1'b1;
    load_len   = len;
    step();
    load_start = 1'b0;
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input int unsigned gap);
    in_valid = 1'b0;
    for (int unsigned i = 0; i < gap; i++) begin
      step();
      check("ready_in_gap", in_ready, 1);
      check("no_write_in_gap", imem_we, 0);
    end
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  // Called right after the last transfer: FLUSH now, RUN with done on the next cycle.
  task automatic finish_load(input logic [DATA_W-1:0] sum);
    check("flush_ready", in_ready, 0);
    check("flush_busy", busy, 1);
    check("flush_core_rst", core_rst, 1);
    step();
    check("run_done", done, 1);
    check("run_core_rst", core_rst, 0);
    check("run_busy", busy, 0);
    check("run_we", imem_we, 0);
    check("run_checksum", checksum, sum);
    step();
    check("done_pulse_end", done, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step();
  endtask

  int unsigned base;
  logic [DATA_W-1:0] sum;

  initial begin
    step(2);
    check("rst_core_rst", core_rst, 1);
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_checksum", checksum, 0);
    check("rst_done_err", {done, err}, 0);
    rst = 1'b0;
    step();

    // Basic 3-word load, back to back
    base = wa.size();
    start(3);
    check("load_ready", in_ready, 1);
    check("load_busy", busy, 1);
    check("load_core_rst", core_rst, 1);
    check("load_we_idle", imem_we, 0);
    send(32'h11, 0);
    check("w0_we", imem_we, 1);
    check("w0_addr", imem_addr, 0);
    check("w0_data", imem_wdata, 32'h11);
    send(32'h22, 0);
    check("w1_addr", imem_addr, 1);
    send(32'h33, 0);
    check("w2_addr", imem_addr, 2);
    check("w2_data", imem_wdata, 32'h33);
    finish_load(32'h66);
    check("basic_nwrites", wa.size() - base, 3);

    // Stalled 2-word load started from RUN
    base = wa.size();
    start(2);
    check("restart_core_rst", core_rst, 1);
    send(32'hA5, 3);
    send(32'h5A, 3);
    finish_load(32'hFF);
    check("stall_nwrites", wa.size() - base, 2);
    check("stall_a0", wa[base], 0);
    check("stall_a1", wa[base+1], 1);
    check("stall_d1", wd[base+1], 32'h5A);

    // Illegal lengths from IDLE
    do_reset();
    base = wa.size();
    start(0);
    check("len0_err", err, 1);
    check("len0_busy", busy, 0);
    check("len0_ready", in_ready, 0);
    check("len0_core_rst", core_rst, 1);
    step();
    check("len0_err_pulse", err, 0);
    start(5'd17);
    check("len17_err", err, 1);
    check("len17_busy", busy, 0);
    in_valid = 1'b1;
    in_data  = 32'hDEAD;
    step(2);
    in_valid = 1'b0;
    check("illegal_nwrites", wa.size() - base, 0);

    // Checksum wrap-around
    start(2);
    send(32'hFFFF_FFFF, 0);
    send(32'h0000_0002, 0);
    finish_load(32'h0000_0001);

    // Reset mid-load
    do_reset();
    base = wa.size();
    start(4);
    send(32'h1, 0);
    send(32'h2, 0);
    in_valid = 1'b1;
    in_data  = 32'h3;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ready", in_ready, 0);
    check("arst_core_rst", core_rst, 1);
    check("arst_we", imem_we, 0);
    check("arst_addr", imem_addr, 0);
    check("arst_checksum", checksum, 0);
    step(2);
    rst = 1'b0;
    step(3);
    in_valid = 1'b0;
    check("arst_idle_busy", busy, 0);
    check("arst_nwrites", wa.size() - base, 2);
    start(1);
    send(32'h7, 0);
    finish_load(32'h7);
    base = wa.size();
    start(2);
    check("rerun_core_rst", core_rst, 1);
    send(32'h9, 0);
    check("rerun_core_rst_load", core_rst, 1);
    send(32'hA, 0);
    finish_load(32'h13);
    check("rerun_a0", wa[base], 0);

    // load_start during LOAD is ignored
    base = wa.size();
    start(3);
    send(32'h10, 0);
    load_start = 1'b1;
    load_len   = 5'd1;
    in_valid   = 1'b1;
    in_data    = 32'h20;
    step();
    load_start = 1'b0;
    in_valid   = 1'b0;
    check("ign_err", err, 0);
    check("ign_busy", busy, 1);
    check("ign_ready", in_ready, 1);
    send(32'h30, 0);
    finish_load(32'h60);
    check("ign_nwrites", wa.size() - base, 3);
    check("ign_a2", wa[base+2], 2);

    // Full-depth load wraps the counter
    base = wa.size();
    start(5'd16);
    sum = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      send(DATA_W'(i * 3 + 1), i % 2);
      sum += DATA_W'(i * 3 + 1);
    end
    finish_load(sum);
    check("full_nwrites", wa.size() - base, 16);
    for (int unsigned i = 0; i < 16; i++) begin
      check("full_addr", wa[base+i], i);
      check("full_data", wd[base+i], i * 3 + 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
